alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_comb.sv | 29 ++
 rtl/alu_exec_unit.sv | 126 ++++++++++++
 tb/tb_alu_exec_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the ALU-control decoder) and
// the execution-unit state encoding.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;

  typedef logic [CTRL_W-1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 4'b0000;
  localparam alu_op_t OP_SUB = 4'b0001;
  localparam alu_op_t OP_AND = 4'b0010;
  localparam alu_op_t OP_OR  = 4'b0011;
  localparam alu_op_t OP_XOR = 4'b0100;
  localparam alu_op_t OP_SLL = 4'b0101;
  localparam alu_op_t OP_SRL = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU evaluation. Shift ops pass op_a through; the multi-cycle
// shift itself is sequenced by the execution unit.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   res_c,
  output logic              illegal_c
);

  always_comb begin
    res_c     = '0;
    illegal_c = 1'b0;
    case (ctrl_i)
      OP_ADD:         res_c = a_i + b_i;
      OP_SUB:         res_c = a_i - b_i;
      OP_AND:         res_c = a_i & b_i;
      OP_OR:          res_c = a_i | b_i;
      OP_XOR:         res_c = a_i ^ b_i;
      OP_SLL, OP_SRL: res_c = a_i;
      default:        illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready handshake, single-cycle ops via alu_comb and
// bit-serial SLL/SRL (one bit per cycle) with a registered result.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0] comb_res;
  logic            comb_ill;
  logic [SHW-1:0]  amt;
  logic [XLEN-1:0] work_shifted;
  logic            accept;

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .ctrl_i    (alu_ctrl),
    .a_i       (op_a),
    .b_i       (op_b),
    .res_c     (comb_res),
    .illegal_c (comb_ill)
  );

  assign amt          = op_b[SHW-1:0];
  assign accept       = in_valid & in_ready_q;
  assign work_shifted = left_q ? (work_q << 1) : (work_q >> 1);

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(alu_ctrl) && (amt != '0)) begin
            state_d = ST_SHIFT;
            work_d  = op_a;
            cnt_d   = amt;
            left_d  = (alu_ctrl == OP_SLL);
          end else begin
            // Shift by zero falls through here: alu_comb yields op_a.
            state_d   = ST_DONE;
            result_d  = comb_res;
            zero_d    = (comb_res == '0);
            illegal_d = comb_ill;
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_shifted;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d   = ST_DONE;
          result_d  = work_shifted;
          zero_d    = (work_shifted == '0);
          illegal_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes hand-computed results,
// a negedge monitor pops and checks each presented result, its timing and hold.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
    int              due;   // edge count after which out_valid must first be seen
    string           name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   seen = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one op; when track is set, push the expected response `edges`
  // clock edges after the accept edge.
  task automatic issue(input string nm, input logic [3:0] c, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] r, input logic z,
                       input logic il, input int edges, input bit track);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      chk({nm, "_ready_timeout"}, 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    tick();
    e.res  = r;
    e.zero = z;
    e.ill  = il;
    e.due  = cyc + edges;
    e.name = nm;
    if (track) sb.push_back(e);
    // Post-accept input changes must not affect the operation.
    in_valid = 1'b0;
    alu_ctrl = 4'hF;
    op_a     = ~a;
    op_b     = ~b;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          cur = sb.pop_front();
          chk({cur.name, "_result"}, 64'(result), 64'(cur.res));
          chk({cur.name, "_zero"}, 64'(zero), 64'(cur.zero));
          chk({cur.name, "_illegal"}, 64'(illegal), 64'(cur.ill));
          chk({cur.name, "_latency"}, 64'(cyc), 64'(cur.due));
        end
        seen = 1'b1;
      end else begin
        chk({cur.name, "_hold_result"}, 64'(result), 64'(cur.res));
        chk({cur.name, "_hold_flags"}, 64'({zero, illegal}), 64'({cur.zero, cur.ill}));
      end
      if (out_ready) seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    tick(); tick();
    chk("reset_outputs", 64'({out_valid, zero, illegal, result}), 64'd0);
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    issue("add_5_7",      4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 0,  1'b1);
    issue("add_wrap",     4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 0,  1'b1);
    issue("sub_eq",       4'b0001, 32'h10,         32'h10,         32'd0,          1'b1, 1'b0, 0,  1'b1);
    issue("sub_borrow",   4'b0001, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 0,  1'b1);
    issue("or",           4'b0011, 32'hA000_0005,  32'h0500_0050,  32'hA500_0055,  1'b0, 1'b0, 0,  1'b1);
    issue("sll_k3",       4'b0101, 32'd1,          32'hFFFF_FFE3,  32'd8,          1'b0, 1'b0, 3,  1'b1);
    issue("srl_k31",      4'b0110, 32'h8000_0000,  32'd31,         32'd1,          1'b0, 1'b0, 31, 1'b1);
    issue("sll_k0",       4'b0101, 32'h1234,       32'hFFFF_FFE0,  32'h1234,       1'b0, 1'b0, 0,  1'b1);
    issue("srl_k0",       4'b0110, 32'h8765_4321,  32'd0,          32'h8765_4321,  1'b0, 1'b0, 0,  1'b1);
    issue("srl_k4",       4'b0110, 32'hF0,         32'd4,          32'hF,          1'b0, 1'b0, 4,  1'b1);
    issue("sll_k1_msb",   4'b0101, 32'h8000_0001,  32'd1,          32'd2,          1'b0, 1'b0, 1,  1'b1);
    issue("srl_to_zero",  4'b0110, 32'd1,          32'd1,          32'd0,          1'b1, 1'b0, 1,  1'b1);
    issue("illegal_1010", 4'b1010, 32'd123,        32'd456,        32'd0,          1'b1, 1'b1, 0,  1'b1);
    issue("and_after",    4'b0010, 32'hFF,         32'h0F,         32'h0F,         1'b0, 1'b0, 0,  1'b1);
    issue("illegal_0111", 4'b0111, 32'd1,          32'd1,          32'd0,          1'b1, 1'b1, 0,  1'b1);
    issue("illegal_1111", 4'b1111, 32'd9,          32'd9,          32'd0,          1'b1, 1'b1, 0,  1'b1);

    // Backpressure: result must be held and no new request accepted.
    while (!in_ready) tick();
    out_ready = 1'b0;
    issue("xor_bp",       4'b0100, 32'hF0F0,       32'h0FF0,       32'hFF00,       1'b0, 1'b0, 0,  1'b1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = 32'd1; op_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);

    // Reset on the 10th cycle of SLL k=20: the result must never appear.
    issue("sll_k20_abort", 4'b0101, 32'h1, 32'd20, 32'd0, 1'b0, 1'b0, 20, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_outputs", 64'({out_valid, zero, illegal, result}), 64'd0);
    rst = 1'b0;
    tick();
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_outputs_after", 64'({out_valid, zero, illegal, result}), 64'd0);
    for (int i = 0; i < 30; i++) tick();

    issue("add_post_rst", 4'b0000, 32'd100,        32'd23,         32'd123,        1'b0, 1'b0, 0,  1'b1);
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin tick(); n++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
